// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback constants: load funct3 codes and datapath widths common
// with the register file.
package writeback_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned SEL_BITS_DEF   = 5;
  localparam int unsigned FUNCT3_W       = 3;

  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_arbiter_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; the head entry is
// visible on rdata whenever the FIFO is non-empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: sole driver of the register-file write port, merging
// single-cycle ALU results with buffered, extended load returns.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned SEL_BITS     = SEL_BITS_DEF,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [SEL_BITS-1:0]   alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_stall,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [SEL_BITS-1:0]   load_rd,
  input  logic [FUNCT3_W-1:0]   load_funct3,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  rf_wEn,
  output logic [SEL_BITS-1:0]   rf_write_sel,
  output logic [DATA_WIDTH-1:0] rf_write_data
);

  localparam int unsigned ENTRY_W = FUNCT3_W + SEL_BITS + DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SC_W    = $clog2(STARVE_LIMIT + 1);

  logic [ENTRY_W-1:0]    head_entry;
  logic [FUNCT3_W-1:0]   head_f3;
  logic [SEL_BITS-1:0]   head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] head_ext;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  alu_win;
  logic [SC_W-1:0]       starve_cnt;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({load_funct3, load_rd, load_data}),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_f3, head_rd, head_data} = head_entry;

  // Handshake and arbitration; everything is masked while reset is high.
  assign load_ready = ~reset & (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push  = load_valid & load_ready & ~fifo_full;
  assign alu_stall  = ~reset & ~fifo_empty & (starve_cnt == SC_W'(STARVE_LIMIT));
  assign alu_win    = ~reset & alu_valid & ~alu_stall;
  assign fifo_pop   = ~reset & ~alu_win & ~fifo_empty;

  // Load width/sign extension applied to the FIFO head.
  always_comb begin
    head_ext = head_data;
    case (head_f3)
      F3_LB:   head_ext = {{(DATA_WIDTH-8){head_data[7]}},   head_data[7:0]};
      F3_LH:   head_ext = {{(DATA_WIDTH-16){head_data[15]}}, head_data[15:0]};
      F3_LBU:  head_ext = {{(DATA_WIDTH-8){1'b0}},           head_data[7:0]};
      F3_LHU:  head_ext = {{(DATA_WIDTH-16){1'b0}},          head_data[15:0]};
      default: head_ext = head_data;
    endcase
  end

  // Registered write port; x0 winners are consumed without a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_wEn        <= 1'b0;
      rf_write_sel  <= '0;
      rf_write_data <= '0;
    end else if (alu_win) begin
      rf_wEn        <= (alu_rd != '0);
      rf_write_sel  <= alu_rd;
      rf_write_data <= alu_data;
    end else if (fifo_pop) begin
      rf_wEn        <= (head_rd != '0);
      rf_write_sel  <= head_rd;
      rf_write_data <= head_ext;
    end else begin
      rf_wEn        <= 1'b0;
    end
  end

  // Counts cycles a queued load is bypassed, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: vector table plus multi-cycle
// sequences, with expected writes queued at drive time and checked on output.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [31:0] load_data;
  logic        rf_wEn;
  logic [4:0]  rf_write_sel;
  logic [31:0] rf_write_data;

  always #5 clock = ~clock;

  writeback_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_stall     (alu_stall),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_rd       (load_rd),
    .load_funct3   (load_funct3),
    .load_data     (load_data),
    .rf_wEn        (rf_wEn),
    .rf_write_sel  (rf_write_sel),
    .rf_write_data (rf_write_data)
  );

  typedef struct { logic wen; logic [4:0] sel; logic [31:0] data; } exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } mload_t;
  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [2:0] f3; logic [31:0] ld; logic [31:0] lexp;
  } vec_t;

  exp_t   exp_q[$];
  mload_t m_fifo[$];
  int     m_starve = 0;
  int     errors = 0;
  int     checks = 0;
  logic   acc_a, acc_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive, check handshakes, queue the expected write, check it.
  task automatic step(input logic rst, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                      input logic [2:0] f3, input logic [31:0] ld, input logic [31:0] lexp,
                      output logic alu_acc, output logic ld_acc);
    exp_t   e;
    mload_t m;
    logic   m_ready, m_stall, was_empty, popped;
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    load_valid = lv; load_rd = lrd; load_funct3 = f3; load_data = ld;
    #1;
    m_ready = !rst && (m_fifo.size() < 4);
    m_stall = !rst && (m_fifo.size() != 0) && (m_starve == 3);
    check("load_ready", 32'(load_ready), 32'(m_ready));
    check("alu_stall", 32'(alu_stall), 32'(m_stall));
    alu_acc = 1'b0;
    ld_acc  = 1'b0;
    e = '{1'b0, 5'd0, 32'd0};
    if (rst) begin
      m_fifo.delete();
      m_starve = 0;
    end else begin
      was_empty = (m_fifo.size() == 0);
      popped = 1'b0;
      if (av && !m_stall) begin
        e = '{(ard != 5'd0), ard, ad};
        alu_acc = 1'b1;
      end else if (!was_empty) begin
        m = m_fifo.pop_front();
        e = '{(m.rd != 5'd0), m.rd, m.data};
        popped = 1'b1;
      end
      if (was_empty || popped) m_starve = 0;
      else if (m_starve < 3) m_starve++;
      if (lv && m_ready) begin
        m_fifo.push_back('{lrd, lexp});
        ld_acc = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("rf_wEn", 32'(rf_wEn), 32'(e.wen));
    if (e.wen) begin
      check("rf_write_sel", 32'(rf_write_sel), 32'(e.sel));
      check("rf_write_data", rf_write_data, e.data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, acc_a, acc_l);
  endtask

  vec_t vecs[12];

  initial begin
    int   alu_k;
    int   ld_idx;
    int   stall_at;
    int   refused_rd;
    logic done;

    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0};
    vecs[1]  = '{1'b1, 5'd0, 32'h0BADF00D, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, F3_LB,  32'h00000080, 32'hFFFFFF80};
    vecs[3]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, F3_LBU, 32'h00000080, 32'h00000080};
    vecs[4]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, F3_LH,  32'h00008000, 32'hFFFF8000};
    vecs[5]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, F3_LW,  32'h12345678, 32'h12345678};
    vecs[6]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, F3_LHU, 32'hFFFFF00F, 32'h0000F00F};
    vecs[7]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, F3_LB,  32'hABCD127F, 32'h0000007F};
    vecs[8]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, F3_LH,  32'h99997FFF, 32'h00007FFF};
    vecs[9]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'b011, 32'hCAFEBABE, 32'hCAFEBABE};
    vecs[10] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'b110, 32'h80000001, 32'h80000001};
    vecs[11] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd0, F3_LW,  32'h11111111, 32'h11111111};

    // Reset held two cycles with ALU traffic present.
    step(1'b1, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, F3_LW, 32'h4, 32'h4, acc_a, acc_l);
    check("reset_sel", 32'(rf_write_sel), 32'd0);
    check("reset_data", rf_write_data, 32'd0);
    step(1'b1, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, F3_LW, 32'h4, 32'h4, acc_a, acc_l);
    idle(1);

    // Table of single transactions, each followed by a drain window.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd,
           vecs[i].f3, vecs[i].ld, vecs[i].lexp, acc_a, acc_l);
      idle(2);
    end

    // Starvation: one load under continuous ALU traffic.
    alu_k = 0;
    stall_at = -1;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b1, 5'd9, 32'hA0000000 + 32'(alu_k), (c == 0), 5'd7, F3_LW,
           32'h55AA0001, 32'h55AA0001, acc_a, acc_l);
      if (!acc_a && stall_at < 0) stall_at = c;
      if (acc_a) alu_k++;
    end
    check("stall_cycle", 32'(stall_at), 32'd4);
    idle(1);

    // Full FIFO: five back-to-back loads while the ALU stays busy.
    ld_idx = 1;
    refused_rd = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step(1'b0, 1'b1, 5'd10, 32'hB0000000 + 32'(c), (ld_idx <= 5), 5'(ld_idx), F3_LW,
           32'h1000 + 32'(ld_idx), 32'h1000 + 32'(ld_idx), acc_a, acc_l);
      if (ld_idx <= 5 && !acc_l && refused_rd == 0) refused_rd = ld_idx;
      if (acc_l) ld_idx++;
      if (ld_idx > 5 && m_fifo.size() == 0) done = 1'b1;
    end
    check("full_drain_done", 32'(done), 32'd1);
    check("first_refused_rd", 32'(refused_rd), 32'd5);
    idle(2);

    // Reset mid-queue discards all queued loads.
    for (int c = 0; c < 3; c++)
      step(1'b0, 1'b1, 5'd11, 32'hC0000000 + 32'(c), 1'b1, 5'(20 + c), F3_LW,
           32'hEE00 + 32'(c), 32'hEE00 + 32'(c), acc_a, acc_l);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, acc_a, acc_l);
    check("count_after_reset", 32'(dut.u_fifo.count), 32'd0);
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
